// File: rtl/biriq_hpm_pkg.sv
// Shared definitions for the hardware performance-monitor unit: CSR address bases,
// mhpmeventh bit positions, the per-counter event record and small decode helpers.
package biriq_hpm_pkg;

   localparam logic [11:0] ADDR_MHPMCOUNTER  = 12'hB00;
   localparam logic [11:0] ADDR_MHPMCOUNTERH = 12'hB80;
   localparam logic [11:0] ADDR_HPMCOUNTER   = 12'hC00;
   localparam logic [11:0] ADDR_HPMCOUNTERH  = 12'hC80;
   localparam logic [11:0] ADDR_MHPMEVENT    = 12'h320;
   localparam logic [11:0] ADDR_MHPMEVENTH   = 12'h720;

   localparam int EVTH_OF_BIT   = 31;
   localparam int EVTH_MINH_BIT = 30;
   localparam int EVTH_SINH_BIT = 29;
   localparam int EVTH_UINH_BIT = 28;

   typedef struct packed {
      logic       of;
      logic       minh;
      logic       uinh;
      logic [4:0] sel;
   } hpm_evt_t;

   typedef enum logic [2:0] {
      REGION_NONE,
      REGION_MCNT,
      REGION_MCNTH,
      REGION_CNT,
      REGION_CNTH,
      REGION_EVT,
      REGION_EVTH
   } hpm_region_e;

   // Each HPM range is 32 entries aligned to 32; entries 0..2 belong to csrfile.
   function automatic logic in_range(logic [11:0] addr, logic [11:0] base);
      return ((addr & 12'hFE0) == base) && (addr[4:0] >= 5'd3);
   endfunction

   function automatic logic [31:0] evth_word(hpm_evt_t evt);
      logic [31:0] word;
      word                = '0;
      word[EVTH_OF_BIT]   = evt.of;
      word[EVTH_MINH_BIT] = evt.minh;
      word[EVTH_SINH_BIT] = 1'b0;
      word[EVTH_UINH_BIT] = evt.uinh;
      return word;
   endfunction

endpackage

// File: rtl/hpm_counter.sv
// One HPM counter: event select, mode/inhibit gating, wrap with overflow detect,
// and the CSR write port for its counter halves and event registers.
module hpm_counter
   import biriq_hpm_pkg::*;
#(
   parameter int COUNTER_WIDTH = 40,
   parameter int NUM_EVENTS    = 16
)(
   input  logic                    cpu_clock_i,
   input  logic                    cpu_reset_i,
   input  logic [2*NUM_EVENTS-1:0] events_i,
   input  logic                    privilege_i,
   input  logic                    inhibit,
   input  logic                    wr_lo,
   input  logic                    wr_hi,
   input  logic                    wr_evt,
   input  logic                    wr_evth,
   input  logic [31:0]             wr_data,
   output logic [63:0]             count,
   output hpm_evt_t                evt,
   output logic                    of_set
);

   logic [COUNTER_WIDTH-1:0] count_q;
   hpm_evt_t                 evt_q;
   logic [63:0]              events_pad;
   logic                     inhibited;
   logic [1:0]               incr;
   logic [COUNTER_WIDTH:0]   sum;
   logic                     cnt_wr;
   logic                     overflow;

   // Zero padding makes selectors beyond NUM_EVENTS pick a constant zero increment.
   assign events_pad = 64'(events_i);
   assign inhibited  = inhibit | (evt_q.minh & privilege_i) | (evt_q.uinh & ~privilege_i);
   assign incr       = inhibited ? 2'd0 : events_pad[{evt_q.sel, 1'b0} +: 2];
   assign sum        = {1'b0, count_q} + {{(COUNTER_WIDTH-1){1'b0}}, incr};
   assign cnt_wr     = wr_lo | wr_hi;
   assign overflow   = sum[COUNTER_WIDTH] & ~cnt_wr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         count_q <= '0;
         evt_q   <= '0;
      end else begin
         if (!cnt_wr) count_q <= sum[COUNTER_WIDTH-1:0];
         if (wr_lo)   count_q[31:0] <= wr_data;
         if (wr_hi)   count_q[COUNTER_WIDTH-1:32] <= wr_data[COUNTER_WIDTH-33:0];
         if (wr_evt)  evt_q.sel <= wr_data[4:0];
         if (wr_evth) begin
            evt_q.minh <= wr_data[EVTH_MINH_BIT];
            evt_q.uinh <= wr_data[EVTH_UINH_BIT];
         end
         // A same-cycle overflow must not be lost to an eventh write clearing OF.
         evt_q.of <= (wr_evth ? wr_data[EVTH_OF_BIT] : evt_q.of) | overflow;
      end
   end

   assign of_set = overflow & ~evt_q.of;
   assign count  = 64'(count_q);
   assign evt    = evt_q;

endmodule

// File: rtl/hpm_unit.sv
// HPM CSR block beside csrfile: decodes the HPM address ranges, checks privilege,
// muxes read data and registers the request response and the overflow interrupt pulse.
module hpm_unit
   import biriq_hpm_pkg::*;
#(
   parameter int NUM_COUNTERS  = 4,
   parameter int COUNTER_WIDTH = 40,
   parameter int NUM_EVENTS    = 16
)(
   input  logic                    cpu_clock_i,
   input  logic                    cpu_reset_i,
   input  logic                    hpm_valid_i,
   input  logic [11:0]             hpm_address_i,
   input  logic                    hpm_wr_en_i,
   input  logic [31:0]             hpm_wr_data_i,
   output logic                    hpm_hit_o,
   output logic [31:0]             hpm_rd_data_o,
   output logic                    hpm_done_o,
   output logic                    hpm_excp_o,
   output logic [31:0]             hpm_data_o,
   input  logic                    privilege_i,
   input  logic [28:0]             mcountinhibit_i,
   input  logic [28:0]             mcounteren_i,
   input  logic [2*NUM_EVENTS-1:0] events_i,
   output logic                    lcofi_set_o
);

   hpm_region_e             region;
   logic [4:0]              idx;
   logic [63:0]             cnt_arr [NUM_COUNTERS];
   hpm_evt_t                evt_arr [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] of_set;
   logic [63:0]             sel_cnt;
   hpm_evt_t                sel_evt;
   logic                    excp;
   logic                    wr_go;
   logic                    unused_inhibit;

   assign idx            = hpm_address_i[4:0];
   assign unused_inhibit = ^mcountinhibit_i;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      region = REGION_NONE;
      if      (in_range(hpm_address_i, ADDR_MHPMCOUNTER))  region = REGION_MCNT;
      else if (in_range(hpm_address_i, ADDR_MHPMCOUNTERH)) region = REGION_MCNTH;
      else if (in_range(hpm_address_i, ADDR_HPMCOUNTER))   region = REGION_CNT;
      else if (in_range(hpm_address_i, ADDR_HPMCOUNTERH))  region = REGION_CNTH;
      else if (in_range(hpm_address_i, ADDR_MHPMEVENT))    region = REGION_EVT;
      else if (in_range(hpm_address_i, ADDR_MHPMEVENTH))   region = REGION_EVTH;
   end

   assign hpm_hit_o = (region != REGION_NONE);

   // Unimplemented indices fall through with zero, which is exactly their read value.
   always_comb begin
      sel_cnt = '0;
      sel_evt = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (int'(idx) == i + 3) begin
            sel_cnt = cnt_arr[i];
            sel_evt = evt_arr[i];
         end
      end
   end

   always_comb begin
      hpm_rd_data_o = '0;
      case (region)
         REGION_MCNT,  REGION_CNT:  hpm_rd_data_o = sel_cnt[31:0];
         REGION_MCNTH, REGION_CNTH: hpm_rd_data_o = sel_cnt[63:32];
         REGION_EVT:                hpm_rd_data_o = {27'b0, sel_evt.sel};
         REGION_EVTH:               hpm_rd_data_o = evth_word(sel_evt);
         default:                   hpm_rd_data_o = '0;
      endcase
   end

   always_comb begin
      excp = 1'b0;
      case (region)
         REGION_MCNT, REGION_MCNTH, REGION_EVT, REGION_EVTH:
            excp = ~privilege_i;
         REGION_CNT, REGION_CNTH:
            excp = hpm_wr_en_i | (~privilege_i & ~mcounteren_i[idx - 5'd3]);
         default:
            excp = 1'b0;
      endcase
   end

   assign wr_go = hpm_valid_i & hpm_wr_en_i & hpm_hit_o & ~excp;

   for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_counter
      logic wr_this;
      assign wr_this = wr_go & (int'(idx) == i + 3);

      hpm_counter #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .NUM_EVENTS    (NUM_EVENTS)
      ) u_counter (
         .cpu_clock_i (cpu_clock_i),
         .cpu_reset_i (cpu_reset_i),
         .events_i    (events_i),
         .privilege_i (privilege_i),
         .inhibit     (mcountinhibit_i[i]),
         .wr_lo       (wr_this & (region == REGION_MCNT)),
         .wr_hi       (wr_this & (region == REGION_MCNTH)),
         .wr_evt      (wr_this & (region == REGION_EVT)),
         .wr_evth     (wr_this & (region == REGION_EVTH)),
         .wr_data     (hpm_wr_data_i),
         .count       (cnt_arr[i]),
         .evt         (evt_arr[i]),
         .of_set      (of_set[i])
      );
   end

   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         hpm_done_o  <= 1'b0;
         hpm_excp_o  <= 1'b0;
         hpm_data_o  <= '0;
         lcofi_set_o <= 1'b0;
      end else begin
         hpm_done_o  <= hpm_valid_i;
         hpm_excp_o  <= hpm_valid_i & excp;
         if (hpm_valid_i) hpm_data_o <= hpm_rd_data_o;
         lcofi_set_o <= |of_set;
      end
   end

endmodule

// File: tb/tb_hpm_unit.sv
// Self-checking bench for hpm_unit: a CSR vector table plus hand-written counting,
// overflow, privilege, inhibit and reset sequences, with responses checked from a queue.
module tb_hpm_unit;

   logic        cpu_clock_i = 1'b0;
   logic        cpu_reset_i = 1'b1;
   logic        hpm_valid_i = 1'b0;
   logic [11:0] hpm_address_i = '0;
   logic        hpm_wr_en_i = 1'b0;
   logic [31:0] hpm_wr_data_i = '0;
   logic        hpm_hit_o;
   logic [31:0] hpm_rd_data_o;
   logic        hpm_done_o;
   logic        hpm_excp_o;
   logic [31:0] hpm_data_o;
   logic        privilege_i = 1'b1;
   logic [28:0] mcountinhibit_i = '0;
   logic [28:0] mcounteren_i = '0;
   logic [31:0] events_i = '0;
   logic        lcofi_set_o;

   hpm_unit #(
      .NUM_COUNTERS  (4),
      .COUNTER_WIDTH (40),
      .NUM_EVENTS    (16)
   ) dut (
      .cpu_clock_i     (cpu_clock_i),
      .cpu_reset_i     (cpu_reset_i),
      .hpm_valid_i     (hpm_valid_i),
      .hpm_address_i   (hpm_address_i),
      .hpm_wr_en_i     (hpm_wr_en_i),
      .hpm_wr_data_i   (hpm_wr_data_i),
      .hpm_hit_o       (hpm_hit_o),
      .hpm_rd_data_o   (hpm_rd_data_o),
      .hpm_done_o      (hpm_done_o),
      .hpm_excp_o      (hpm_excp_o),
      .hpm_data_o      (hpm_data_o),
      .privilege_i     (privilege_i),
      .mcountinhibit_i (mcountinhibit_i),
      .mcounteren_i    (mcounteren_i),
      .events_i        (events_i),
      .lcofi_set_o     (lcofi_set_o)
   );

   always #5 cpu_clock_i = ~cpu_clock_i;

   typedef struct {
      logic [31:0] data;
      logic        excp;
   } exp_t;

   typedef struct {
      logic        priv;
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        hit;
      logic [31:0] exp_data;
      logic        exp_excp;
   } vec_t;

   int   checks    = 0;
   int   failures  = 0;
   int   pulse_cnt = 0;
   exp_t sb_q[$];
   vec_t tbl [21];

   always @(negedge cpu_clock_i) begin
      if (lcofi_set_o === 1'b1) pulse_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One CSR request: drive for a cycle, then compare the registered response to the queue head.
   task automatic csr(input string name, input logic [11:0] addr, input logic we,
                      input logic [31:0] wdata, input logic exp_hit,
                      input logic [31:0] exp_data, input logic exp_excp);
      exp_t e;
      hpm_valid_i   = 1'b1;
      hpm_address_i = addr;
      hpm_wr_en_i   = we;
      hpm_wr_data_i = wdata;
      #1;
      check({name, " hit"}, 64'(hpm_hit_o), 64'(exp_hit));
      sb_q.push_back('{exp_data, exp_excp});
      @(posedge cpu_clock_i);
      #1;
      hpm_valid_i = 1'b0;
      hpm_wr_en_i = 1'b0;
      check({name, " done"}, 64'(hpm_done_o), 64'd1);
      e = sb_q.pop_front();
      check({name, " data"}, 64'(hpm_data_o), 64'(e.data));
      check({name, " excp"}, 64'(hpm_excp_o), 64'(e.excp));
   endtask

   task automatic run_events(input logic [31:0] ev, input int cycles);
      events_i = ev;
      repeat (cycles) @(posedge cpu_clock_i);
      #1;
      events_i = '0;
   endtask

   initial begin
      int p0;

      tbl[0]  = '{1'b1, 12'h323, 1'b1, 32'hFFFF_FFE2, 1'b1, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b1, 12'h323, 1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b0};
      tbl[2]  = '{1'b1, 12'h723, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
      tbl[3]  = '{1'b1, 12'h723, 1'b0, 32'h0,         1'b1, 32'hD000_0000, 1'b0};
      tbl[4]  = '{1'b1, 12'h723, 1'b1, 32'h0,         1'b1, 32'hD000_0000, 1'b0};
      tbl[5]  = '{1'b1, 12'h723, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      tbl[6]  = '{1'b1, 12'hB83, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
      tbl[7]  = '{1'b1, 12'hB83, 1'b0, 32'h0,         1'b1, 32'h0000_00FF, 1'b0};
      tbl[8]  = '{1'b1, 12'hB83, 1'b1, 32'h0,         1'b1, 32'h0000_00FF, 1'b0};
      tbl[9]  = '{1'b1, 12'hB1F, 1'b1, 32'h5,         1'b1, 32'h0000_0000, 1'b0};
      tbl[10] = '{1'b1, 12'hB1F, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      tbl[11] = '{1'b1, 12'hB02, 1'b1, 32'h5,         1'b0, 32'h0000_0000, 1'b0};
      tbl[12] = '{1'b1, 12'h000, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0};
      tbl[13] = '{1'b1, 12'hC03, 1'b1, 32'h1234,      1'b1, 32'h0000_0000, 1'b1};
      tbl[14] = '{1'b1, 12'hC83, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      tbl[15] = '{1'b0, 12'hB03, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
      tbl[16] = '{1'b0, 12'h323, 1'b1, 32'h3,         1'b1, 32'h0000_0002, 1'b1};
      tbl[17] = '{1'b1, 12'h323, 1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b0};
      tbl[18] = '{1'b1, 12'h726, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
      tbl[19] = '{1'b1, 12'h727, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
      tbl[20] = '{1'b1, 12'h727, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};

      repeat (3) @(posedge cpu_clock_i);
      #1;
      check("reset done",  64'(hpm_done_o),  64'd0);
      check("reset excp",  64'(hpm_excp_o),  64'd0);
      check("reset data",  64'(hpm_data_o),  64'd0);
      check("reset lcofi", 64'(lcofi_set_o), 64'd0);
      cpu_reset_i = 1'b0;
      csr("reset cnt3", 12'hB03, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         privilege_i = tbl[i].priv;
         csr($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].wdata,
             tbl[i].hit, tbl[i].exp_data, tbl[i].exp_excp);
      end
      privilege_i = 1'b1;
      check("no pulse from OF write", 64'(pulse_cnt), 64'd0);

      // Ten cycles of +1 on event 2.
      run_events(32'h10, 10);
      csr("count10 lo",  12'hB03, 1'b0, 32'h0, 1'b1, 32'd10, 1'b0);
      csr("count10 hi",  12'hB83, 1'b0, 32'h0, 1'b1, 32'd0,  1'b0);
      csr("count10 ro",  12'hC03, 1'b0, 32'h0, 1'b1, 32'd10, 1'b0);

      // Wrap by +2 from all-ones: counter 1, OF set, exactly one pulse.
      csr("ovf wr lo", 12'hB03, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd10, 1'b0);
      csr("ovf wr hi", 12'hB83, 1'b1, 32'hFF,        1'b1, 32'd0,  1'b0);
      p0 = pulse_cnt;
      run_events(32'h20, 1);
      check("ovf lcofi", 64'(lcofi_set_o), 64'd1);
      csr("ovf lo",   12'hB03, 1'b0, 32'h0, 1'b1, 32'd1, 1'b0);
      check("ovf lcofi drop", 64'(lcofi_set_o), 64'd0);
      csr("ovf hi",   12'hB83, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      csr("ovf evth", 12'h723, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      check("ovf one pulse", 64'(pulse_cnt), 64'(p0 + 1));

      // Second wrap (+3) while OF already set: no further pulse.
      csr("ovf2 wr lo", 12'hB03, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b0);
      csr("ovf2 wr hi", 12'hB83, 1'b1, 32'hFF,        1'b1, 32'd0, 1'b0);
      run_events(32'h30, 1);
      csr("ovf2 lo", 12'hB03, 1'b0, 32'h0, 1'b1, 32'd2, 1'b0);
      check("ovf2 no pulse", 64'(pulse_cnt), 64'(p0 + 1));

      // U-mode access to hpmcounter3 gated by mcounteren.
      privilege_i = 1'b0;
      csr("u ro no en",  12'hC03, 1'b0, 32'h0,  1'b1, 32'd2, 1'b1);
      mcounteren_i = 29'h1;
      csr("u ro en",     12'hC03, 1'b0, 32'h0,  1'b1, 32'd2, 1'b0);
      csr("u wr ro",     12'hC03, 1'b1, 32'h55, 1'b1, 32'd2, 1'b1);
      csr("u ro after",  12'hC03, 1'b0, 32'h0,  1'b1, 32'd2, 1'b0);
      privilege_i = 1'b1;

      // Mode inhibits and mcountinhibit.
      csr("clr of",   12'h723, 1'b1, 32'h0,         1'b1, 32'h8000_0000, 1'b0);
      csr("clr lo",   12'hB03, 1'b1, 32'h0,         1'b1, 32'd2,         1'b0);
      csr("set minh", 12'h723, 1'b1, 32'h4000_0000, 1'b1, 32'h0,         1'b0);
      run_events(32'h10, 5);
      csr("minh m",   12'hB03, 1'b0, 32'h0,         1'b1, 32'd0,         1'b0);
      privilege_i = 1'b0;
      run_events(32'h10, 4);
      csr("minh u",   12'hC03, 1'b0, 32'h0,         1'b1, 32'd4,         1'b0);
      mcountinhibit_i = 29'h1;
      run_events(32'h10, 3);
      csr("inhibit",  12'hC03, 1'b0, 32'h0,         1'b1, 32'd4,         1'b0);
      mcountinhibit_i = '0;
      privilege_i = 1'b1;
      csr("set uinh", 12'h723, 1'b1, 32'h1000_0000, 1'b1, 32'h4000_0000, 1'b0);
      privilege_i = 1'b0;
      run_events(32'h10, 2);
      privilege_i = 1'b1;
      run_events(32'h10, 2);
      csr("uinh",     12'hB03, 1'b0, 32'h0,         1'b1, 32'd6,         1'b0);
      csr("clr uinh", 12'h723, 1'b1, 32'h0,         1'b1, 32'h1000_0000, 1'b0);

      // Counter write in a +3 cycle: the write wins.
      events_i = 32'h30;
      csr("wr vs inc", 12'hB03, 1'b1, 32'h100, 1'b1, 32'd6, 1'b0);
      events_i = '0;
      csr("wr wins lo", 12'hB03, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      csr("wr wins hi", 12'hB83, 1'b0, 32'h0, 1'b1, 32'h0,   1'b0);

      // Two counters overflowing in one cycle give a single pulse.
      csr("sel4",    12'h324, 1'b1, 32'h3,         1'b1, 32'h0,   1'b0);
      csr("c3 lo",   12'hB03, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h100, 1'b0);
      csr("c3 hi",   12'hB83, 1'b1, 32'hFF,        1'b1, 32'h0,   1'b0);
      csr("c4 lo",   12'hB04, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,   1'b0);
      csr("c4 hi",   12'hB84, 1'b1, 32'hFF,        1'b1, 32'h0,   1'b0);
      p0 = pulse_cnt;
      run_events(32'h50, 1);
      check("dual lcofi", 64'(lcofi_set_o), 64'd1);
      csr("dual of3", 12'h723, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      csr("dual of4", 12'h724, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      csr("dual c4",  12'hB04, 1'b0, 32'h0, 1'b1, 32'd0,         1'b0);
      check("dual one pulse", 64'(pulse_cnt), 64'(p0 + 1));

      // Reset mid-request, with counter 3 about to overflow.
      csr("pre rst of", 12'h723, 1'b1, 32'h0,         1'b1, 32'h8000_0000, 1'b0);
      csr("pre rst lo", 12'hB03, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0,         1'b0);
      csr("pre rst hi", 12'hB83, 1'b1, 32'hFF,        1'b1, 32'd0,         1'b0);
      p0 = pulse_cnt;
      events_i      = 32'h10;
      hpm_valid_i   = 1'b1;
      hpm_address_i = 12'hB03;
      hpm_wr_en_i   = 1'b0;
      cpu_reset_i   = 1'b1;
      @(posedge cpu_clock_i);
      #1;
      check("rst done",  64'(hpm_done_o),  64'd0);
      check("rst excp",  64'(hpm_excp_o),  64'd0);
      check("rst data",  64'(hpm_data_o),  64'd0);
      check("rst lcofi", 64'(lcofi_set_o), 64'd0);
      hpm_valid_i = 1'b0;
      cpu_reset_i = 1'b0;
      events_i    = '0;
      @(posedge cpu_clock_i);
      #1;
      check("rst no done", 64'(hpm_done_o), 64'd0);
      csr("rst c3 lo", 12'hB03, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      csr("rst c3 hi", 12'hB83, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      csr("rst evt3",  12'h323, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      csr("rst evth4", 12'h724, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      csr("rst c4 lo", 12'hB04, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0);
      check("rst no pulse", 64'(pulse_cnt), 64'(p0));
      check("scoreboard drained", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
